shift_sched_2req: RTL and testbench
===================================

# shift_sched_2req

Two-requester scheduler that shares one serial shift path between two parallel-word sources. It arbitrates round-robin, loads the winning word, and shifts it out MSB first with a frame-valid qualifier. It then enforces a programmable idle gap before the next arbitration. It sits in front of the serial shift-register chain and sequences it on behalf of both producers.

## Interface
- WIDTH, default 4: bits per frame; legal range WIDTH >= 2.
- IDLE_GAP, default 1: idle cycles after each frame; 0 is legal.
- clock  in  1  single clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- req0, req1  in  1  level request; sampled only in IDLE.
- data0, data1  in  WIDTH  word for each requester; held stable while its req is high.
- gnt0, gnt1  out  1  one-cycle registered acceptance pulse.
- sout  out  1  serial data, MSB first.
- sout_valid  out  1  high while a frame bit is on sout.
- owner  out  1  index of the requester whose frame is in flight.
- busy  out  1  high from the grant cycle through the last gap cycle.
- done  out  1  one-cycle pulse coincident with the last bit of the frame.

## Operation
- States: IDLE, SHIFT, GAP, plus PARITY when the configuration macro is defined.
- All outputs are registered; every output resets to 0.
- Reset state is IDLE with the round-robin pointer `last` = 1, so req0 wins first.
- IDLE, no req: stay in IDLE; outputs 0.
- IDLE, exactly one req: grant it.
- IDLE, both reqs: grant the requester != `last`.
- On the grant edge:
  - shreg <= dataX; `last` <= X; owner <= X; cnt <= 0; state <= SHIFT.
  - gntX = 1 for the following cycle only.
- SHIFT:
  - sout = shreg[WIDTH-1]; sout_valid = 1; busy = 1.
  - Each edge: shreg shifts left and cnt increments.
  - After WIDTH bits, go to GAP, or to IDLE if IDLE_GAP = 0.
- GAP: sout_valid = 0, sout = 0, busy = 1 for IDLE_GAP cycles, then IDLE.
- Requester protocol: deassert req by the edge after gnt is seen, unless another frame is wanted. A held req re-arbitrates at the next IDLE.
- cnt is $clog2(WIDTH+1) bits wide; the gap counter is $clog2(IDLE_GAP+1) bits wide, minimum 1.
- req changes outside IDLE are ignored; nothing is queued.
- clear mid-frame: all outputs drop to 0 immediately and the frame is aborted with no done pulse. The pointer returns to `last` = 1, and a pending requester must keep req high to be re-granted.

## Timing
- req high at edge k while in IDLE gives gnt, owner and first sout bit valid in cycle k+1.
- The data bits occupy cycles k+1 .. k+WIDTH; done is high in cycle k+WIDTH.
- Frame-start period with req held: WIDTH + IDLE_GAP + 1 cycles. This includes one IDLE arbitration cycle, so sout_valid is low for at least IDLE_GAP+1 cycles between frames.
- Combinational path from req to outputs: none.

## Configuration
- SHIFT_SCHED_PARITY_EN defined:
  - After the WIDTH data bits, one PARITY cycle drives sout = XOR of the frame word (even parity) with sout_valid = 1.
  - done moves to the parity cycle.
  - Period becomes WIDTH + IDLE_GAP + 2.
- Not defined: no PARITY state; frames are exactly WIDTH bits.

## Test plan
- Reset: clear=1 drives all outputs to 0; after release with no req, outputs stay 0 for 20 cycles.
- WIDTH=4, IDLE_GAP=1, req0 with data0=4'b1011 at edge 0:
  - gnt0 is high in cycle 1 only.
  - sout is 1,0,1,1 in cycles 1-4 with sout_valid high and owner=0.
  - done is high in cycle 4; busy falls after cycle 5.
- req0 and req1 both held with data0=4'hA and data1=4'h5: grants alternate 0,1,0,1; sout frames are 1010, 0101, 1010; starts are 6 cycles apart.
- clear pulsed during the second bit of a req1 frame: outputs go to 0 at once and no done pulse occurs. After release with both reqs held, req0 is granted first.
- IDLE_GAP=0, req0 held: sout_valid is low for exactly 1 cycle between consecutive frames.
- SHIFT_SCHED_PARITY_EN defined:
  - data0=4'b0111 gives a 5th bit of 1, with done on that bit.
  - data0=4'b0110 gives a 5th bit of 0.

Source files
------------

// File: rtl/shift_sched_2req.sv
//==============================================================================
// Module  : shift_sched_2req
// Brief   : Round-robin scheduler that serialises one of two parallel words
//           MSB first, then holds off for IDLE_GAP cycles. Optional even-parity
//           trailer bit when SHIFT_SCHED_PARITY_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module shift_sched_2req #(
   parameter int WIDTH    = 4,
   parameter int IDLE_GAP = 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sout,
   output logic             sout_valid,
   output logic             owner,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
   localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
   localparam logic [GW-1:0] c_GAP_LAST = GW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

`ifdef SHIFT_SCHED_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_GAP    = 2'd2,
      S_PARITY = 2'd3
   } state_t;
`else
   localparam logic [CW-1:0] c_CNT_PEN = CW'(WIDTH - 2);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;
`endif

   state_t           r_state;
   logic             r_last;
   logic [WIDTH-2:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic [GW-1:0]    r_gcnt;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_sout;
   logic             r_valid;
   logic             r_owner;
   logic             r_busy;
   logic             r_done;
`ifdef SHIFT_SCHED_PARITY_EN
   logic             r_par;
`endif

   logic             w_any;
   logic             w_pick1;
   logic [WIDTH-1:0] w_word;
   logic             w_end;

   assign w_any   = req0 | req1;
   // req1 wins when alone, or when both ask and req0 went last
   assign w_pick1 = req1 & (~req0 | ~r_last);
   assign w_word  = w_pick1 ? data1 : data0;

`ifdef SHIFT_SCHED_PARITY_EN
   assign w_end = (r_state == S_PARITY);
`else
   assign w_end = (r_state == S_SHIFT) && (r_cnt == c_CNT_LAST);
`endif

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_gcnt  <= '0;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
         r_owner <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SHIFT_SCHED_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_SHIFT;
                  r_last  <= w_pick1;
                  r_owner <= w_pick1;
                  r_gnt0  <= ~w_pick1;
                  r_gnt1  <= w_pick1;
                  // MSB goes straight to sout; shreg keeps the remaining bits
                  r_sout  <= w_word[WIDTH-1];
                  r_shreg <= w_word[WIDTH-2:0];
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef SHIFT_SCHED_PARITY_EN
                  r_par   <= ^w_word;
`endif
               end
            end
            S_SHIFT: begin
               r_shreg <= r_shreg << 1;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt != c_CNT_LAST) begin
                  r_sout <= r_shreg[WIDTH-2];
`ifndef SHIFT_SCHED_PARITY_EN
                  r_done <= (r_cnt == c_CNT_PEN);
`endif
               end
`ifdef SHIFT_SCHED_PARITY_EN
               else begin
                  r_state <= S_PARITY;
                  r_sout  <= r_par;
                  r_done  <= 1'b1;
               end
`endif
            end
            S_GAP: begin
               if (r_gcnt == c_GAP_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_owner <= 1'b0;
               end else begin
                  r_gcnt <= r_gcnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Frame finished: drop the serial qualifier and either gap or rearm
         if (w_end) begin
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_gcnt  <= '0;
            if (IDLE_GAP == 0) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_owner <= 1'b0;
            end else begin
               r_state <= S_GAP;
            end
         end
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign sout       = r_sout;
   assign sout_valid = r_valid;
   assign owner      = r_owner;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_sched_2req.sv
//==============================================================================
// Module  : tb_shift_sched_2req
// Brief   : Scoreboard bench for shift_sched_2req (WIDTH=4, IDLE_GAP=1 and 0).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_shift_sched_2req;

`ifdef SHIFT_SCHED_PARITY_EN
   localparam bit c_PAR = 1'b1;
`else
   localparam bit c_PAR = 1'b0;
`endif
   localparam int c_PERIOD = 4 + 1 + 1 + (c_PAR ? 1 : 0);

   logic       clk = 1'b0;
   logic       clear;
   logic       req0, req1;
   logic [3:0] data0, data1;
   logic       gnt0, gnt1, sout, sout_valid, owner, busy, done;

   logic       b_req0;
   logic [3:0] b_data0;
   logic       b_gnt0, b_gnt1, b_sout, b_valid, b_owner, b_busy, b_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [4:0] q[$];

   shift_sched_2req #(.WIDTH(4), .IDLE_GAP(1)) dut (
      .clock(clk), .clear(clear), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
      .sout(sout), .sout_valid(sout_valid), .owner(owner),
      .busy(busy), .done(done)
   );

   shift_sched_2req #(.WIDTH(4), .IDLE_GAP(0)) dut_b (
      .clock(clk), .clear(clear), .req0(b_req0), .req1(1'b0),
      .data0(b_data0), .data1(4'h0), .gnt0(b_gnt0), .gnt1(b_gnt1),
      .sout(b_sout), .sout_valid(b_valid), .owner(b_owner),
      .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected record per frame bit: {gnt0, gnt1, owner, sout, done}
   task automatic push_frame(input bit own, input logic [3:0] d, input bit par);
      for (int i = 0; i < 4; i++)
         q.push_back({(i == 0) && !own, (i == 0) && own, own, d[3-i], (i == 3) && !c_PAR});
      if (c_PAR) q.push_back({1'b0, 1'b0, own, par, 1'b1});
   endtask

   task automatic wait_gnt();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(gnt0 | gnt1) && n < 40);
      if (!(gnt0 | gnt1)) chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 40);
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // Monitor: pops one expected record for every valid serial bit
   always @(negedge clk) begin
      if (!clear) begin
         if (sout_valid) begin
            if (q.size() == 0) chk("unexpected_bit", 1, 0);
            else chk("frame_bit", {27'd0, gnt0, gnt1, owner, sout, done}, {27'd0, q.pop_front()});
         end else begin
            chk("quiet_when_invalid", {28'd0, gnt0, gnt1, sout, done}, 32'd0);
         end
      end
   end

   initial begin
      int gcyc[4];
      int ng;
      int seen, low, gaps;
      bit prev;

      clear = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      b_req0 = 1'b0; b_data0 = '0;
      @(negedge clk);
      chk("reset_outputs", {25'd0, gnt0, gnt1, sout, sout_valid, owner, busy, done}, 32'd0);
      chk("reset_outputs_b", {25'd0, b_gnt0, b_gnt1, b_sout, b_valid, b_owner, b_busy, b_done}, 32'd0);
      @(posedge clk); #1 clear = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_no_req", {25'd0, gnt0, gnt1, sout, sout_valid, owner, busy, done}, 32'd0);
      end

      // Single frame 1011 from req0
      @(posedge clk); #1 data0 = 4'b1011; req0 = 1'b1;
      push_frame(1'b0, 4'b1011, 1'b1);
      wait_gnt();
      req0 = 1'b0;
      begin
         int n = 0;
         while (!done && n < 20) begin @(negedge clk); n++; end
         chk("done_seen", {31'd0, done}, 32'd1);
      end
      @(negedge clk);
      chk("gap_busy", {30'd0, busy, sout_valid}, 32'd2);
      @(negedge clk);
      chk("busy_falls", {31'd0, busy}, 32'd0);

      // Reset the pointer, then both requesters held
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      data0 = 4'hA; data1 = 4'h5; req0 = 1'b1; req1 = 1'b1;
      push_frame(1'b0, 4'hA, 1'b0);
      push_frame(1'b1, 4'h5, 1'b0);
      push_frame(1'b0, 4'hA, 1'b0);
      push_frame(1'b1, 4'h5, 1'b0);
      ng = 0;
      for (int n = 0; n < 100 && ng < 4; n++) begin
         @(negedge clk);
         if (gnt0 | gnt1) begin
            gcyc[ng] = cyc;
            ng++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("grant_count", ng, 4);
      for (int i = 1; i < 4; i++) chk("start_spacing", gcyc[i] - gcyc[i-1], c_PERIOD);
      wait_idle();

      // Abort a req1 frame on its second bit; both held afterwards, req0 first
      data1 = 4'h5; req1 = 1'b1;
      q.push_back(5'b01100);
      q.push_back(5'b00110);
      wait_gnt();
      @(posedge clk); #7 clear = 1'b1;
      #1 chk("clear_outputs", {25'd0, gnt0, gnt1, sout, sout_valid, owner, busy, done}, 32'd0);
      chk("abort_bits_consumed", q.size(), 0);
      data0 = 4'hA; req0 = 1'b1;
      push_frame(1'b0, 4'hA, 1'b0);
      @(posedge clk); #1 clear = 1'b0;
      wait_gnt();
      chk("first_after_clear", {30'd0, gnt0, gnt1}, 32'd2);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      // Parity-relevant words (odd and even ones count)
      data0 = 4'b0111; req0 = 1'b1;
      push_frame(1'b0, 4'b0111, 1'b1);
      wait_gnt(); req0 = 1'b0;
      wait_idle();
      data0 = 4'b0110; req0 = 1'b1;
      push_frame(1'b0, 4'b0110, 1'b0);
      wait_gnt(); req0 = 1'b0;
      wait_idle();

      // IDLE_GAP=0 instance: exactly one invalid cycle between frames
      b_data0 = 4'h9; b_req0 = 1'b1;
      seen = 0; low = 0; gaps = 0; prev = 1'b0;
      for (int n = 0; n < 80 && gaps < 3; n++) begin
         @(negedge clk);
         if (b_valid && !prev) begin
            if (seen > 0) begin
               chk("gap0_low_cycles", low, 1);
               gaps++;
            end
            seen++;
            low = 0;
         end else if (!b_valid) begin
            low++;
         end
         prev = b_valid;
      end
      b_req0 = 1'b0;
      chk("gap0_gaps_seen", gaps, 3);

      repeat (12) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
